// File: rtl/encoder8_3_pkg.sv
// Shared types and helpers for the registered 8-to-3 event encoder.
// Holds the FSM state type, the inactive input level and the priority function.
package encoder8_3_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] IDLE_LEVEL = 8'hFF;

    // Index of the winning set bit; returns 0 for an empty mask.
    function automatic logic [2:0] prio_enc8(input logic [7:0] mask, input logic high_first);
        logic [2:0] idx;
        idx = '0;
        if (high_first) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/encoder8_3_event_deb_bit.sv
// One-bit debouncer: the output follows the input only after DEB_CYCLES
// consecutive samples that differ from the current output level.
module deb_bit #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_reg;
    logic          q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            q_reg   <= 1'b1;
        end else if (d == q_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
            q_reg   <= d;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/encoder8_3_event.sv
// Registered 8-to-3 priority encoder with falling-edge event queue and VALID/READY output.
// Optional input debouncing is enabled by defining DEBOUNCE_EN.
module encoder8_3_event
    import encoder8_3_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter int DEB_CYCLES    = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] N,
    input  logic       READY,
    output logic [2:0] CBA,
    output logic       VALID,
    output logic       GS_N,
    output logic       OVF,
    input  logic       CLR_OVF
);
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_param_check
        $error("encoder8_3_event: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
    end

    logic [7:0]       sync_reg [SYNC_STAGES];
    logic [7:0]       level;
    logic [7:0]       prev_reg;
    logic [ARM_W-1:0] arm_cnt_reg;
    logic [7:0]       pend_reg, pend_next;
    logic [2:0]       cba_reg, cba_next;
    logic             ovf_reg, ovf_next;
    state_t           state_reg, state_next;

    logic             armed;
    logic [7:0]       fall;
    logic             load;
    logic [2:0]       sel_idx;
    logic [7:0]       clear_mask, held_mask, kept;
    logic             ovf_hit;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [7:0] stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = N;
            end else begin : g_rest
                assign stage_in = sync_reg[gi-1];
            end
            always_ff @(posedge CLK) begin
                if (!RST_N) sync_reg[gi] <= IDLE_LEVEL;
                else        sync_reg[gi] <= stage_in;
            end
        end
    endgenerate

`ifdef DEBOUNCE_EN
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_deb
            deb_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (CLK),
                .rst_n (RST_N),
                .d     (sync_reg[SYNC_STAGES-1][gi]),
                .q     (level[gi])
            );
        end
    endgenerate
`else
    assign level = sync_reg[SYNC_STAGES-1];
`endif

    // Lines already low at reset release must not look like fresh falls.
    assign armed = (arm_cnt_reg == ARM_W'(ARM_CYCLES));
    assign fall  = armed ? (prev_reg & ~level) : 8'h00;

    always_comb begin
        state_next = state_reg;
        cba_next   = cba_reg;
        load       = 1'b0;
        sel_idx    = prio_enc8(pend_reg, PRIORITY_HIGH);
        case (state_reg)
            IDLE: if (|pend_reg) load = 1'b1;
            HOLD: begin
                if (READY) begin
                    if (|pend_reg) load = 1'b1;
                    else           state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            state_next = HOLD;
            cba_next   = sel_idx;
        end
        clear_mask = load ? (8'b1 << sel_idx) : 8'h00;
        // The index still shown on CBA after this edge counts as outstanding.
        held_mask  = (state_reg == HOLD && !READY) ? (8'b1 << cba_reg) : 8'h00;
        kept       = pend_reg & ~clear_mask;
        ovf_hit    = |(fall & (kept | held_mask));
        pend_next  = kept | (fall & ~held_mask);
        ovf_next   = ovf_hit | (ovf_reg & ~CLR_OVF);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev_reg    <= IDLE_LEVEL;
            arm_cnt_reg <= '0;
            pend_reg    <= '0;
            cba_reg     <= '0;
            ovf_reg     <= 1'b0;
            state_reg   <= IDLE;
        end else begin
            prev_reg    <= level;
            if (!armed) arm_cnt_reg <= arm_cnt_reg + 1'b1;
            pend_reg    <= pend_next;
            cba_reg     <= cba_next;
            ovf_reg     <= ovf_next;
            state_reg   <= state_next;
        end
    end

    assign CBA   = cba_reg;
    assign VALID = (state_reg == HOLD);
    assign GS_N  = ~((|pend_reg) | VALID);
    assign OVF   = ovf_reg;

endmodule

// File: tb/tb_encoder8_3_event.sv
// Self-checking bench for encoder8_3_event: directed tables, corner sequences,
// and randomized traffic compared with a per-event reference model.
module tb_encoder8_3_event;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] n = 8'hFF;
    logic       ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] cba;
    logic       valid, gs_n, ovf;

    int checks = 0;
    int errors = 0;
    bit cmp_model = 1'b0;

    // Reference model: raw input history plus a set of waiting requests.
    logic [7:0] hist [0:SYNC];
    logic [7:0] m_pend = 8'h00;
    logic       m_valid = 1'b0;
    logic [2:0] m_cba = 3'd0;
    logic       m_ovf = 1'b0;
    int         m_since = 0;

    typedef struct {
        logic [7:0] n;
        logic [2:0] cba;
    } vec_t;
    vec_t vecs [6];

    encoder8_3_event dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .N       (n),
        .READY   (ready),
        .CBA     (cba),
        .VALID   (valid),
        .GS_N    (gs_n),
        .OVF     (ovf),
        .CLR_OVF (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] n_i, input logic rdy, input logic clr, input logic rst);
        logic [7:0] fall, new_pend;
        int chosen, held;
        bit hit;
        if (!rst) begin
            for (int j = 0; j <= SYNC; j++) hist[j] = 8'hFF;
            m_pend = 8'h00; m_valid = 1'b0; m_cba = 3'd0; m_ovf = 1'b0; m_since = 0;
            return;
        end
        fall = hist[SYNC] & ~hist[SYNC-1];
        if (m_since < SYNC + 1) fall = 8'h00;
        held = (m_valid && !rdy) ? int'(m_cba) : -1;
        chosen = -1;
        if ((!m_valid || rdy) && m_pend != 8'h00)
            for (int i = 0; i < 8; i++) if (m_pend[i]) chosen = i;
        new_pend = m_pend;
        if (chosen >= 0) new_pend[chosen] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (fall[i]) begin
                if (i == held || (m_pend[i] && i != chosen)) hit = 1'b1;
                else new_pend[i] = 1'b1;
            end
        end
        if (chosen >= 0) begin
            m_valid = 1'b1;
            m_cba = 3'(chosen);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_ovf = hit ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_pend = new_pend;
        for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = n_i;
        if (m_since < 1000) m_since++;
    endtask

    task automatic step(input logic [7:0] n_i, input logic rdy, input logic clr, input logic rst);
        n = n_i; ready = rdy; clr_ovf = clr; rst_n = rst;
        @(posedge clk);
        model_edge(n_i, rdy, clr, rst);
        #1;
        if (cmp_model) begin
            chk("model_valid", int'(valid), int'(m_valid));
            if (m_valid) chk("model_cba", int'(cba), int'(m_cba));
            chk("model_ovf", int'(ovf), int'(m_ovf));
            chk("model_gs_n", int'(gs_n), int'(!(m_pend != 8'h00 || m_valid)));
        end
    endtask

    initial begin
        logic [7:0] rn;
        logic [2:0] cba_seen;
        int lat;
        bit found;

        vecs[0] = '{8'hFB, 3'd2};
        vecs[1] = '{8'h7F, 3'd7};
        vecs[2] = '{8'hFE, 3'd0};
        vecs[3] = '{8'h5E, 3'd7};
        vecs[4] = '{8'hEF, 3'd4};
        vecs[5] = '{8'h00, 3'd7};
        for (int j = 0; j <= SYNC; j++) hist[j] = 8'hFF;

        // Reset and idle
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(8'hFF, 1'b0, 1'b0, 1'b1);
            chk("idle_valid", int'(valid), 0);
            chk("idle_gs_n", int'(gs_n), 1);
            chk("idle_cba", int'(cba), 0);
            chk("idle_ovf", int'(ovf), 0);
        end
        $display("txn idle: 20 cycles with no request");

`ifdef DEBOUNCE_EN
        // Short low glitch is filtered, long low passes after the debounce delay
        for (int k = 0; k < 10; k++) begin
            step(8'hFD, 1'b1, 1'b0, 1'b1);
            chk("deb_short_valid", int'(valid), 0);
        end
        for (int k = 0; k < 40; k++) begin
            step(8'hFF, 1'b1, 1'b0, 1'b1);
            chk("deb_short_valid", int'(valid), 0);
        end
        for (int k = 1; k <= 24; k++) begin
            step(8'hFD, 1'b1, 1'b0, 1'b1);
            chk("deb_long_valid", int'(valid), int'(k == 20));
            if (k == 20) chk("deb_long_cba", int'(cba), 1);
        end
        $display("txn debounce: short low ignored, long low delivered");
`else
        // Single held request: one-cycle pulse, no retrigger
        for (int k = 1; k <= 15; k++) begin
            step(8'hFB, 1'b1, 1'b0, 1'b1);
            chk("single_valid", int'(valid), int'(k == 4));
            if (k == 4) chk("single_cba", int'(cba), 2);
        end
        repeat (5) step(8'hFF, 1'b1, 1'b0, 1'b1);
        $display("txn single: CBA=2 once");

        // Priority table with latency measurement
        for (int v = 0; v < 6; v++) begin
            repeat (12) step(8'hFF, 1'b1, 1'b0, 1'b1);
            found = 1'b0; lat = 0; cba_seen = 3'd0;
            for (int k = 1; k <= 8 && !found; k++) begin
                step(vecs[v].n, 1'b1, 1'b0, 1'b1);
                if (valid) begin
                    found = 1'b1; lat = k; cba_seen = cba;
                end
            end
            chk("tbl_latency", lat, SYNC + 2);
            chk("tbl_cba", int'(cba_seen), int'(vecs[v].cba));
            repeat (10) step(vecs[v].n, 1'b1, 1'b0, 1'b1);
            $display("txn table %0d: N=%h first CBA=%0d latency=%0d", v, vecs[v].n, cba_seen, lat);
        end
        repeat (12) step(8'hFF, 1'b1, 1'b0, 1'b1);

        // Stall then back-to-back drain 7,5,0
        for (int k = 1; k <= 14; k++) begin
            step(8'h5E, 1'b0, 1'b0, 1'b1);
            if (k >= 4) begin
                chk("stall_valid", int'(valid), 1);
                chk("stall_cba", int'(cba), 7);
            end
        end
        step(8'h5E, 1'b1, 1'b0, 1'b1);
        chk("b2b_cba5", int'(cba), 5);
        chk("b2b_valid5", int'(valid), 1);
        step(8'h5E, 1'b1, 1'b0, 1'b1);
        chk("b2b_cba0", int'(cba), 0);
        chk("b2b_valid0", int'(valid), 1);
        step(8'h5E, 1'b1, 1'b0, 1'b1);
        chk("b2b_done_valid", int'(valid), 0);
        chk("b2b_done_gs_n", int'(gs_n), 1);
        repeat (5) step(8'hFF, 1'b1, 1'b0, 1'b1);
        $display("txn stall: 7 held, then 7,5,0");

        // Re-assertion of the held bit sets OVF and merges
        step(8'hF7, 1'b0, 1'b0, 1'b1);
        step(8'hF7, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        chk("ovf_first_cba", int'(cba), 3);
        chk("ovf_pre", int'(ovf), 0);
        step(8'hF7, 1'b0, 1'b0, 1'b1);
        step(8'hF7, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_held_valid", int'(valid), 1);
        chk("ovf_held_cba", int'(cba), 3);
        step(8'hFF, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk("ovf_single_delivery", int'(valid), 0);
            step(8'hFF, 1'b1, 1'b0, 1'b1);
        end
        chk("ovf_sticky", int'(ovf), 1);
        step(8'hFF, 1'b1, 1'b1, 1'b1);
        chk("ovf_cleared", int'(ovf), 0);
        $display("txn overflow: bit 3 merged, OVF set then cleared");

        // Reset during HOLD with a line held low across release
        repeat (5) step(8'h5E, 1'b0, 1'b0, 1'b1);
        chk("rst_pre_valid", int'(valid), 1);
        chk("rst_pre_cba", int'(cba), 7);
        step(8'hEF, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_gs_n", int'(gs_n), 1);
        for (int k = 0; k < 20; k++) begin
            step(8'hEF, 1'b1, 1'b0, 1'b1);
            chk("rst_hold_valid", int'(valid), 0);
            chk("rst_hold_gs_n", int'(gs_n), 1);
        end
        repeat (10) step(8'hFF, 1'b1, 1'b0, 1'b1);
        $display("txn reset: in-flight and held requests dropped");

        // Randomized traffic against the model
        cmp_model = 1'b1;
        rn = 8'hFF;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) rn = rn ^ (8'b1 << $urandom_range(0, 7));
            step(rn, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 299) != 0);
        end
        cmp_model = 1'b0;
        $display("txn random: 3000 cycles compared");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
